lna_trx_sequencer: RTL and testbench

Sequences the power LNA front end between receive and transmit. It owns the LNA supply-enable, EnableReceive and EnableTransmit control lines. It arbitrates receive and transmit requests from the baseband and enforces power-up settling, break-before-make guard intervals and a maximum transmit burst length. It sits between the baseband MAC and the PowerLNA analog block.

---
 rtl/lna_ctrl_pkg.sv | 25 ++
 rtl/lna_trx_sequencer_if.sv | 25 ++
 rtl/lna_seq_timer.sv | 40 ++++
 rtl/lna_trx_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lna_trx_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lna_ctrl_pkg.sv
// Shared types and default timing for the LNA RX/TX sequencer.
// State encodings are visible on the debug State output, so their values are fixed.
package lna_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StSettle = 3'd1,
        StIdle   = 3'd2,
        StRx     = 3'd3,
        StTx     = 3'd4,
        StGuard  = 3'd5
    } lna_state_e;

    typedef enum logic [1:0] {
        TgtIdle = 2'd0,
        TgtRx   = 2'd1,
        TgtTx   = 2'd2
    } lna_tgt_e;

    localparam int unsigned SettleCyclesDef = 64;
    localparam int unsigned GuardCyclesDef  = 8;
    localparam int unsigned TxMaxCyclesDef  = 4096;
    localparam int unsigned CntWDef         = 13;

endpackage

// File: rtl/lna_trx_sequencer_if.sv
// Baseband <-> sequencer signal bundle: level requests in, LNA controls and status out.
interface lna_trx_sequencer_if;

    logic       PowerReq;
    logic       RxReq;
    logic       TxReq;
    logic       SupplyOn;
    logic       EnableReceive;
    logic       EnableTransmit;
    logic       RxActive;
    logic       TxActive;
    logic       TxTimeout;
    logic [2:0] State;

    modport master (
        output PowerReq, RxReq, TxReq,
        input  SupplyOn, EnableReceive, EnableTransmit, RxActive, TxActive, TxTimeout, State
    );

    modport slave (
        input  PowerReq, RxReq, TxReq,
        output SupplyOn, EnableReceive, EnableTransmit, RxActive, TxActive, TxTimeout, State
    );

endinterface

// File: rtl/lna_seq_timer.sv
// Loadable up/down counter shared by settle, guard and TX watchdog timing.
// Load wins over count; tc_o flags a count of zero.
module lna_seq_timer #(
    parameter int unsigned CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - CNT_W'(1);
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/lna_trx_sequencer.sv
// Power/RX/TX sequencer for the LNA front end: settle after power-up, break-before-make
// guard on every changeover, and a TX burst watchdog with lockout until TxReq drops.
module lna_trx_sequencer
    import lna_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SettleCyclesDef,
    parameter int unsigned GUARD_CYCLES  = GuardCyclesDef,
    parameter int unsigned TX_MAX_CYCLES = TxMaxCyclesDef,
    parameter int unsigned CNT_W         = CntWDef
) (
    input logic                Clock,
    input logic                ResetN,
    lna_trx_sequencer_if.slave lna_io
);

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GuardLoad  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TxLast     = CNT_W'(TX_MAX_CYCLES - 1);

    lna_state_e       state_d, state_q;
    lna_tgt_e         tgt_d, tgt_q;
    logic             lock_d, lock_q;
    logic             timeout_d, timeout_q;
    logic             supply_q, en_rx_q, en_tx_q;
    logic             tmr_load, tmr_dec, tmr_inc, tmr_tc;
    logic [CNT_W-1:0] tmr_load_val, tmr_count;

    logic pwr, rx, tx, tx_ok;
    assign pwr   = lna_io.PowerReq;
    assign rx    = lna_io.RxReq;
    assign tx    = lna_io.TxReq;
    assign tx_ok = tx && !lock_q;

    lna_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (Clock),
        .rst_ni     (ResetN),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .inc_i      (tmr_inc),
        .count_o    (tmr_count),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        timeout_d    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        tmr_inc      = 1'b0;

        case (state_q)
            StOff: begin
                if (pwr) begin
                    state_d      = StSettle;
                    tmr_load     = 1'b1;
                    tmr_load_val = SettleLoad;
                end
            end
            StSettle: begin
                if (!pwr)        state_d = StOff;
                else if (tmr_tc) state_d = StIdle;
                else             tmr_dec = 1'b1;
            end
            StIdle: begin
                if (!pwr) begin
                    state_d = StOff;
                end else if (tx_ok) begin
                    state_d  = StTx;
                    tmr_load = 1'b1;
                end else if (rx) begin
                    state_d = StRx;
                end
            end
            StRx: begin
                if (!pwr) begin
                    state_d = StOff;
                end else if (tx_ok) begin
                    state_d      = StGuard;
                    tgt_d        = TgtTx;
                    tmr_load     = 1'b1;
                    tmr_load_val = GuardLoad;
                end else if (!rx) begin
                    state_d = StIdle;
                end
            end
            StTx: begin
                if (!pwr) begin
                    state_d = StOff;
                end else if (!tx) begin
                    state_d      = StGuard;
                    tgt_d        = rx ? TgtRx : TgtIdle;
                    tmr_load     = 1'b1;
                    tmr_load_val = GuardLoad;
                end else if (tmr_count == TxLast) begin
                    state_d      = StGuard;
                    tgt_d        = TgtIdle;
                    timeout_d    = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = GuardLoad;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            StGuard: begin
                if (!pwr) begin
                    state_d = StOff;
                end else if (tmr_tc) begin
                    // Fall back to IDLE if the target's request went away during the guard
                    case (tgt_q)
                        TgtRx:   state_d = rx ? StRx : StIdle;
                        TgtTx: begin
                            state_d  = tx ? StTx : StIdle;
                            tmr_load = tx;
                        end
                        default: state_d = StIdle;
                    endcase
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = StOff;
        endcase

        if (state_d == StOff) begin
            tmr_load     = 1'b1;
            tmr_load_val = '0;
            tmr_dec      = 1'b0;
            tmr_inc      = 1'b0;
        end

        lock_d = lock_q;
        if (timeout_d)  lock_d = 1'b1;
        else if (!tx)   lock_d = 1'b0;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= StOff;
            tgt_q     <= TgtIdle;
            lock_q    <= 1'b0;
            timeout_q <= 1'b0;
            supply_q  <= 1'b0;
            en_rx_q   <= 1'b0;
            en_tx_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
            supply_q  <= (state_d != StOff);
            en_rx_q   <= (state_d == StRx);
            en_tx_q   <= (state_d == StTx);
        end
    end

    assign lna_io.SupplyOn       = supply_q;
    assign lna_io.EnableReceive  = en_rx_q;
    assign lna_io.EnableTransmit = en_tx_q;
    assign lna_io.RxActive       = en_rx_q;
    assign lna_io.TxActive       = en_tx_q;
    assign lna_io.TxTimeout      = timeout_q;
    assign lna_io.State          = state_q;

endmodule

// File: tb/tb_lna_trx_sequencer.sv
// Directed scenarios plus a long randomized run, all checked every cycle against a
// phase/age reference model of the sequencing rules.
module tb_lna_trx_sequencer;

    localparam int Settle = 64;
    localparam int Guard  = 8;
    localparam int TxMax  = 16;

    localparam int PhOff = 0, PhSettle = 1, PhIdle = 2, PhRx = 3, PhTx = 4, PhGuard = 5;
    localparam int GoIdle = 0, GoRx = 1, GoTx = 2;

    logic Clock;
    logic ResetN;

    lna_trx_sequencer_if bus ();

    lna_trx_sequencer #(
        .SETTLE_CYCLES (Settle),
        .GUARD_CYCLES  (Guard),
        .TX_MAX_CYCLES (TxMax),
        .CNT_W         (13)
    ) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .lna_io (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: phase, cycles spent in the phase, guard goal, TX lockout
    int m_phase, m_age, m_goal;
    bit m_lock, m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {23'b0, bus.SupplyOn, bus.EnableReceive, bus.EnableTransmit, bus.RxActive,
                bus.TxActive, bus.TxTimeout, bus.State};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic on, r, t;
        on = (m_phase != PhOff);
        r  = (m_phase == PhRx);
        t  = (m_phase == PhTx);
        return {23'b0, on, r, t, r, t, m_pulse, 3'(m_phase)};
    endfunction

    task automatic model_reset();
        m_phase = PhOff;
        m_age   = 0;
        m_goal  = GoIdle;
        m_lock  = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_age   = 0;
    endtask

    task automatic model_step(input bit p, input bit r, input bit t);
        bit tmo;
        tmo = 1'b0;
        if (!p && m_phase != PhOff) begin
            enter(PhOff);
        end else begin
            case (m_phase)
                PhOff:    if (p) enter(PhSettle);
                PhSettle: if (m_age == Settle - 1) enter(PhIdle); else m_age++;
                PhIdle: begin
                    if (t && !m_lock) enter(PhTx);
                    else if (r)       enter(PhRx);
                end
                PhRx: begin
                    if (t && !m_lock) begin
                        m_goal = GoTx;
                        enter(PhGuard);
                    end else if (!r) begin
                        enter(PhIdle);
                    end
                end
                PhTx: begin
                    if (!t) begin
                        m_goal = r ? GoRx : GoIdle;
                        enter(PhGuard);
                    end else if (m_age == TxMax - 1) begin
                        m_goal = GoIdle;
                        tmo    = 1'b1;
                        enter(PhGuard);
                    end else begin
                        m_age++;
                    end
                end
                PhGuard: begin
                    if (m_age == Guard - 1) begin
                        if (m_goal == GoRx && r)               enter(PhRx);
                        else if (m_goal == GoTx && t && !m_lock) enter(PhTx);
                        else                                   enter(PhIdle);
                    end else begin
                        m_age++;
                    end
                end
                default: enter(PhOff);
            endcase
        end
        m_pulse = tmo;
        if (tmo)     m_lock = 1'b1;
        else if (!t) m_lock = 1'b0;
    endtask

    // Advance one clock and compare every output against the model on the falling edge
    task automatic cycle();
        @(posedge Clock);
        if (!ResetN) model_reset();
        else model_step(bus.PowerReq, bus.RxReq, bus.TxReq);
        @(negedge Clock);
        check("outputs", obs_vec(), exp_vec());
        check("rx_tx_exclusive", 32'(bus.EnableReceive & bus.EnableTransmit), 32'd0);
        check("enable_without_supply",
              32'((bus.EnableReceive | bus.EnableTransmit) & ~bus.SupplyOn), 32'd0);
    endtask

    initial begin
        bit p, r, t;
        ResetN       = 1'b0;
        bus.PowerReq = 1'b0;
        bus.RxReq    = 1'b0;
        bus.TxReq    = 1'b0;
        model_reset();
        #1;
        check("reset_state", obs_vec(), 32'd0);
        repeat (3) cycle();
        ResetN = 1'b1;

        // Power-up and settle
        bus.PowerReq = 1'b1;
        cycle();
        check("supply_cycle1", 32'(bus.SupplyOn), 32'd1);
        repeat (63) cycle();
        check("settle_cycle64", 32'(bus.State), 32'd1);
        cycle();
        check("idle_cycle65", 32'(bus.State), 32'd2);
        bus.RxReq = 1'b1;
        cycle();
        check("rx_latency", 32'(bus.EnableReceive), 32'd1);

        // RX -> TX preemption through the guard
        bus.TxReq = 1'b1;
        cycle();
        check("rx_drops", 32'(bus.EnableReceive), 32'd0);
        for (int i = 0; i < Guard - 1; i++) begin
            cycle();
            check("guard_both_off", 32'({bus.EnableReceive, bus.EnableTransmit}), 32'd0);
        end
        cycle();
        check("tx_after_guard", 32'(bus.EnableTransmit), 32'd1);

        // Watchdog and lockout
        bus.RxReq = 1'b0;
        for (int i = 0; i < TxMax - 1; i++) begin
            cycle();
            check("tx_held", 32'({bus.EnableTransmit, bus.TxTimeout}), 32'd2);
        end
        cycle();
        check("watchdog_fires", 32'({bus.EnableTransmit, bus.TxTimeout}), 32'd1);
        cycle();
        check("timeout_one_cycle", 32'(bus.TxTimeout), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("tx_locked_out", 32'(bus.EnableTransmit), 32'd0);
        end
        bus.TxReq = 1'b0;
        cycle();
        bus.TxReq = 1'b1;
        cycle();
        check("tx_reentry", 32'(bus.EnableTransmit), 32'd1);

        // Power drop during TX
        bus.PowerReq = 1'b0;
        cycle();
        check("power_drop", obs_vec(), 32'd0);

        // Requests dropped during the guard
        bus.TxReq    = 1'b0;
        bus.PowerReq = 1'b1;
        repeat (65) cycle();
        bus.RxReq = 1'b1;
        cycle();
        check("rx_again", 32'(bus.State), 32'd3);
        bus.TxReq = 1'b1;
        cycle();
        bus.TxReq = 1'b0;
        bus.RxReq = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("dropped_guard_off", 32'({bus.EnableReceive, bus.EnableTransmit}), 32'd0);
        end
        check("guard_to_idle", 32'(bus.State), 32'd2);

        // Asynchronous reset in the middle of a guard
        bus.RxReq = 1'b1;
        cycle();
        bus.TxReq = 1'b1;
        repeat (3) cycle();
        check("in_guard", 32'(bus.State), 32'd5);
        #2 ResetN = 1'b0;
        #1;
        check("async_reset", obs_vec(), 32'd0);
        model_reset();
        cycle();
        ResetN    = 1'b1;
        bus.TxReq = 1'b0;
        bus.RxReq = 1'b0;

        // Randomized levels with sticky requests so states persist
        p = 1'b1;
        r = 1'b0;
        t = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (p) p = ($urandom_range(299) != 0);
            else   p = ($urandom_range(9) == 0);
            if ($urandom_range(14) == 0) r = ~r;
            if ($urandom_range(24) == 0) t = ~t;
            bus.PowerReq = p;
            bus.RxReq    = r;
            bus.TxReq    = t;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
